// File: rtl/discrete_randomizer_pkg.sv
// Shared constants, FSM encoding and mask helper for the discrete range randomizer.
package discrete_randomizer_pkg;

    localparam int DEFAULT_INTEGER_WIDTH     = 8;
    localparam int DEFAULT_VAR_INDEX_WIDTH   = 8;
    localparam int DEFAULT_CHOICE_WIDTH      = 4;
    localparam int DEFAULT_REJECT_LIMIT      = 4;
    localparam int LFSR_WIDTH                = 16;

    localparam logic [15:0] LFSR_TAPS          = 16'hB400;
    localparam logic [15:0] DEFAULT_LFSR_SEED  = 16'hACE1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PICK    = 3'd1;
    localparam logic [2:0] ST_LOOKUP  = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_SAMPLE  = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // Smear the highest set bit downwards: smallest 2^n-1 that is >= value.
    function automatic logic [15:0] smallest_all_ones_mask(input logic [15:0] value);
        logic [15:0] m;
        m = value;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        return m;
    endfunction

endpackage

// File: rtl/lfsr_galois_16.sv
// 16-bit Galois LFSR, right-shifting, free running outside reset.
module lfsr_galois_16
    import discrete_randomizer_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_LFSR_SEED
) (
    input  logic        in_clock,
    input  logic        in_reset,
    output logic [15:0] out_state
);

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            out_state <= SEED;
        end else begin
            out_state <= {1'b0, out_state[15:1]} ^ (out_state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/discrete_range_sampler.sv
// Picks a random discrete choice for a variable, reads its [start,end] range
// from the lookup table and emits one uniformly distributed value inside it.
//
// state   | meaning
// IDLE    | waiting for in_start
// PICK    | drawing a choice index (rejection sampling)
// LOOKUP  | address stable, table registers its output
// CAPTURE | latch lower bound, span and span mask
// SAMPLE  | drawing an offset inside the span (rejection sampling)
// DONE    | out_valid pulse
module discrete_range_sampler
    import discrete_randomizer_pkg::*;
#(
    parameter int          MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = DEFAULT_INTEGER_WIDTH,
    parameter int          MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = DEFAULT_VAR_INDEX_WIDTH,
    parameter int          MAX_BIT_WIDTH_OF_DISCRETE_CHOICES = DEFAULT_CHOICE_WIDTH,
    parameter logic [15:0] LFSR_SEED                         = DEFAULT_LFSR_SEED,
    parameter int          REJECT_LIMIT                      = DEFAULT_REJECT_LIMIT
) (
    input  logic                                         in_clock,
    input  logic                                         in_reset,
    input  logic                                         in_start,
    input  logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]  in_variable_index,
    input  logic [MAX_BIT_WIDTH_OF_DISCRETE_CHOICES-1:0] in_number_of_choices_minus_one,
    output logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]  out_variable_index,
    output logic [MAX_BIT_WIDTH_OF_DISCRETE_CHOICES-1:0] out_index_of_the_discrete_value,
    input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_table_start,
    input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_table_end,
    output logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] out_value,
    output logic                                         out_valid,
    output logic                                         out_busy
);

    localparam int W  = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
    localparam int C  = MAX_BIT_WIDTH_OF_DISCRETE_CHOICES;
    localparam int RW = (REJECT_LIMIT < 1) ? 1 : $clog2(REJECT_LIMIT + 1);

    logic [2:0]    state;
    logic [C-1:0]  count_m1;
    logic [RW-1:0] reject_cnt;
    logic [W-1:0]  lo;
    logic [W-1:0]  span;
    logic [W-1:0]  smask;
    logic [15:0]   lfsr_state;

    logic [15:0]   cmask_full;
    logic [15:0]   smask_full;
    logic [C-1:0]  k;
    logic [W-1:0]  d;
    logic          limit_hit;
    logic [W-1:0]  cap_lo;
    logic [W-1:0]  cap_span;
    logic          unused_bits;

    lfsr_galois_16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .in_clock  (in_clock),
        .in_reset  (in_reset),
        .out_state (lfsr_state)
    );

    // Swapped bounds are legal: lo is always the smaller one.
    always_comb begin
        cap_lo   = in_table_start;
        cap_span = in_table_end - in_table_start;
        if (in_table_start > in_table_end) begin
            cap_lo   = in_table_end;
            cap_span = in_table_start - in_table_end;
        end
    end

    assign cmask_full  = smallest_all_ones_mask(16'(count_m1));
    assign smask_full  = smallest_all_ones_mask(16'(cap_span));
    assign k           = lfsr_state[C-1:0] & cmask_full[C-1:0];
    assign d           = lfsr_state[W-1:0] & smask;
    assign limit_hit   = (reject_cnt == RW'(REJECT_LIMIT));
    assign unused_bits = ^{lfsr_state, cmask_full, smask_full};

    assign out_busy  = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state                           <= ST_IDLE;
            count_m1                        <= '0;
            reject_cnt                      <= '0;
            lo                              <= '0;
            span                            <= '0;
            smask                           <= '0;
            out_variable_index              <= '0;
            out_index_of_the_discrete_value <= '0;
            out_value                       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_start) begin
                        out_variable_index <= in_variable_index;
                        count_m1           <= in_number_of_choices_minus_one;
                        reject_cnt         <= '0;
                        state              <= ST_PICK;
                    end
                end
                ST_PICK: begin
                    // k>>1 never exceeds count_m1 because the mask is the tightest one.
                    if (k <= count_m1) begin
                        out_index_of_the_discrete_value <= k;
                        reject_cnt                      <= '0;
                        state                           <= ST_LOOKUP;
                    end else if (limit_hit) begin
                        out_index_of_the_discrete_value <= k >> 1;
                        reject_cnt                      <= '0;
                        state                           <= ST_LOOKUP;
                    end else begin
                        reject_cnt <= reject_cnt + RW'(1);
                    end
                end
                ST_LOOKUP: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    lo    <= cap_lo;
                    span  <= cap_span;
                    smask <= smask_full[W-1:0];
                    state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (d <= span) begin
                        out_value  <= lo + d;
                        reject_cnt <= '0;
                        state      <= ST_DONE;
                    end else if (limit_hit) begin
                        out_value  <= lo + (d >> 1);
                        reject_cnt <= '0;
                        state      <= ST_DONE;
                    end else begin
                        reject_cnt <= reject_cnt + RW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
